vdff_pipe: RTL
==============

Name: vdff_pipe

Overview:
- Parametrised multi-stage delay line; successor to the single-stage delayed flop.
- Configurable data width and maximum depth, with a per-stage valid bit, a global stall enable, a synchronous flush, and a delay tap selectable at run time.
- Used wherever a datapath must be re-aligned by a variable number of clock cycles, e.g. matching the latency of a memory read against its side-band data.

Parameters:
- SIZE, 5, data width in bits; must be >= 1.
- DEPTH, 4, number of pipeline stages, equal to the maximum delay in cycles; must be >= 1.
- SEL_W, $clog2(DEPTH+1), width of delay_sel; localparam, derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  stage advance enable; 0 = every stage holds.
- flush  input  1  synchronous clear of all stage valid bits.
- in  input  SIZE  data entering stage 0.
- in_valid  input  1  qualifies in.
- delay_sel  input  SEL_W  requested delay in cycles.
- out  output  SIZE  data of the selected stage.
- out_valid  output  1  valid bit of the selected stage.

Behaviour:
- Storage:
  - Stage registers s[0..DEPTH-1], each holding SIZE data bits and 1 valid bit.
  - Stage 0 captures in/in_valid; stage k captures stage k-1.
- Reset: while rst is high, all stage data = 0 and all valid bits = 0. Consequently out = 0 and out_valid = 0. Reset takes effect immediately, including mid-stream; no partial shift completes.
- Advance: on a rising clk edge with en = 1 and flush = 0, every stage shifts by one. Bubbles (in_valid = 0) shift through like data.
- Stall: with en = 0 and flush = 0, all stage data and valid bits hold; out and out_valid hold.
- Flush:
  - flush = 1 clears every valid bit on the next edge, regardless of en. Flush has priority over en.
  - Data bits are not cleared by flush.
  - A beat presented with in_valid = 1 in the flush cycle is dropped; stage 0 valid becomes 0.
- Tap selection:
  - Effective delay d = delay_sel, clamped to the range 1..DEPTH.
  - delay_sel = 0 is treated as 1; delay_sel > DEPTH is treated as DEPTH.
  - out = s[d-1].data and out_valid = s[d-1].valid, as a combinational mux from registers with no logic from in to out.
- Latency: a beat accepted at edge N appears at out after edge N+d-1, i.e. d rising edges counting the capture edge, provided en stays 1 throughout. Each cycle with en = 0 adds one cycle of latency.
- Changing delay_sel:
  - The tap switches in the same cycle; no re-timing occurs.
  - Shortening d skips beats held in deeper stages; lengthening d replays beats already output.
  - Both effects are intended. Callers change delay_sel only while the pipe is empty or flushed.
- Degenerate case DEPTH = 1: a single flop with valid; delay_sel is ignored.

Optional Feature:
- Macro: VDFF_PIPE_OCC_EN.
- Defined:
  - Adds output port occ (SEL_W bits): the count of stages whose valid bit = 1 across all DEPTH stages, independent of delay_sel.
  - occ is a registered counter, not a popcount, updated on the same edge as the stages:
    - +1 when in_valid enters and s[DEPTH-1].valid leaves as 0.
    - -1 when the reverse happens.
    - Unchanged otherwise or when en = 0.
  - Reset and flush both set occ to 0.
  - occ never exceeds DEPTH.
- Undefined: the occ port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: SIZE = 8, DEPTH = 4. Hold rst high, drive in = 0xFF, in_valid = 1, en = 1. Required: out = 0x00 and out_valid = 0 throughout. With the macro defined, occ = 0.
- Fixed delay: delay_sel = 3. Drive 0x11, 0x22, 0x33 on consecutive cycles, valid, en = 1. Required: out = 0x11 with out_valid = 1 exactly 3 edges after the first capture, then 0x22 and 0x33 on the following cycles.
- Stall: delay_sel = 2. Drive 0xA5 valid, then deassert en for 3 cycles immediately after capture. Required: 0xA5 appears 5 edges after capture, and out holds its previous value while en = 0.
- Flush priority: fill all 4 stages valid. Assert flush with en = 0 and in_valid = 1 (in = 0x5A). Required: out_valid = 0 next cycle for every delay_sel; 0x5A never appears. With the macro defined, occ = 0.
- Clamp: delay_sel = 0 gives 1-cycle latency; delay_sel = 7 (SEL_W = 3, DEPTH = 4) gives 4-cycle latency, checked with a single beat 0x3C.
- Async reset mid-stream: with beats in flight, pulse rst between clock edges. Required: out_valid drops to 0 before the next edge, and no stale beat emerges after rst is released.

Source files
------------

// File: rtl/vdff_pipe.sv
// Variable-tap delay line: DEPTH stages with valid bits, stall, flush and a clamped run-time tap.
// Optional: define VDFF_PIPE_OCC_EN to add the registered occupancy counter port occ.

module vdff_stage #(
    parameter int SIZE = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end
endmodule

module vdff_pipe #(
    parameter  int SIZE  = 5,
    parameter  int DEPTH = 4,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [SIZE-1:0]  in,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] delay_sel,
    output logic [SIZE-1:0]  out,
`ifdef VDFF_PIPE_OCC_EN
    output logic [SEL_W-1:0] occ,
`endif
    output logic             out_valid
);
    logic [DEPTH-1:0][SIZE-1:0] data_pipe;
    logic [DEPTH-1:0]           vld_pipe;
    logic [SEL_W-1:0]           tap;
    logic                       advance;

    // Data holds on flush; only the valid bits are cleared.
    assign advance = en & ~flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            vdff_stage #(.SIZE(SIZE)) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (advance),
                .d   (in),
                .q   (data_pipe[k])
            );
        end else begin : g_body
            vdff_stage #(.SIZE(SIZE)) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (advance),
                .d   (data_pipe[k-1]),
                .q   (data_pipe[k])
            );
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          vld_pipe <= '0;
        else if (flush)   vld_pipe <= '0;
        else if (en) begin
            if (DEPTH > 1) vld_pipe <= {vld_pipe[DEPTH-1:0], in_valid} >> 0;
            else           vld_pipe <= in_valid;
        end
    end

    // Clamp delay_sel into 1..DEPTH and convert to a stage index.
    always_comb begin
        tap = '0;
        if (delay_sel == '0)                  tap = '0;
        else if (delay_sel >= SEL_W'(DEPTH))  tap = SEL_W'(DEPTH - 1);
        else                                  tap = delay_sel - SEL_W'(1);
    end

    always_comb begin
        out       = '0;
        out_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap == SEL_W'(k)) begin
                out       = data_pipe[k];
                out_valid = vld_pipe[k];
            end
        end
    end

`ifdef VDFF_PIPE_OCC_EN
    logic inc, dec;

    assign inc = in_valid & ~vld_pipe[DEPTH-1];
    assign dec = ~in_valid & vld_pipe[DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             occ <= '0;
        else if (flush)      occ <= '0;
        else if (en) begin
            if (inc)         occ <= occ + SEL_W'(1);
            else if (dec)    occ <= occ - SEL_W'(1);
        end
    end
`endif

endmodule
